// File: rtl/vx_barrier_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vx_barrier_unit_pkg
// Purpose  : Shared types and constants for the local barrier unit.
//            bar_req_t mirrors the barrier fields carried on the warp-control
//            interface; bar_release_t is the release message sent to the
//            warp scheduler.
// Contents : NUM_WARPS_DEF, NUM_BARRIERS_DEF, NW_WIDTH, NB_WIDTH,
//            clog2_min1(), bar_req_t, bar_release_t
// Revision : 1.0  initial release
// ============================================================================
package vx_barrier_unit_pkg;

    localparam int NUM_WARPS_DEF    = 4;
    localparam int NUM_BARRIERS_DEF = 4;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NW_WIDTH = clog2_min1(NUM_WARPS_DEF);
    localparam int NB_WIDTH = clog2_min1(NUM_BARRIERS_DEF);

    typedef struct packed {
        logic                valid;
        logic [NW_WIDTH-1:0] wid;
        logic [NB_WIDTH-1:0] id;
        logic [NW_WIDTH-1:0] size_m1;
        logic                is_noop;
    } bar_req_t;

    typedef struct packed {
        logic                     valid;
        logic [NUM_WARPS_DEF-1:0] wmask;
    } bar_release_t;

endpackage
`default_nettype wire

// File: rtl/vx_barrier_slot.sv
`default_nettype none
// ============================================================================
// Module   : vx_barrier_slot
// Purpose  : State for one barrier id: arrival count and arrived-warp mask.
//            Presents the duplicate / last-arrival decision and the mask that
//            would be released, and updates its state when selected.
// Ports    : clk, reset          clock, async active-high reset
//            req_en              request targets this id (noop excluded)
//            req_wid             arriving warp
//            req_size_m1         participating warps minus 1
//            wmask               current arrived-warp mask
//            is_dup              arriving warp already waiting here
//            is_last             this arrival completes the barrier
//            rel_mask            mask released if is_last
// Revision : 1.0  initial release
// ============================================================================
module vx_barrier_slot #(
    parameter int NUM_WARPS = 4,
    parameter int NW_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_en,
    input  logic [NW_W-1:0]      req_wid,
    input  logic [NW_W-1:0]      req_size_m1,
    output logic [NUM_WARPS-1:0] wmask,
    output logic                 is_dup,
    output logic                 is_last,
    output logic [NUM_WARPS-1:0] rel_mask
);

    logic [NW_W-1:0]      r_cnt;
    logic [NUM_WARPS-1:0] r_wmask;
    logic [NUM_WARPS-1:0] w_onehot;

    assign w_onehot = NUM_WARPS'(1) << req_wid;
    assign is_dup   = |(r_wmask & w_onehot);
    assign is_last  = (r_cnt == req_size_m1);
    assign rel_mask = r_wmask | w_onehot;
    assign wmask    = r_wmask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_wmask <= '0;
        end else if (req_en && !is_dup) begin
            if (is_last) begin
                r_cnt   <= '0;
                r_wmask <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_wmask <= r_wmask | w_onehot;
            end
        end
    end

`ifndef SYNTHESIS
    // The first arrival fixes the barrier size; later arrivals must agree.
    logic [NW_W-1:0] r_first_size;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first_size <= '0;
        end else if (req_en && !is_dup && (r_wmask == '0)) begin
            r_first_size <= req_size_m1;
        end
    end

    a_size_consistent: assert property (@(posedge clk) disable iff (reset)
        (req_en && !is_dup && (r_wmask != '0)) |-> (req_size_m1 == r_first_size));
`endif

endmodule
`default_nettype wire

// File: rtl/vx_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module   : vx_barrier_unit
// Purpose  : Per-core local barrier manager. Tracks arrivals per barrier id
//            and emits a registered release mask to the warp scheduler one
//            cycle after the last warp arrives (or after a noop barrier).
// Ports    : clk, reset          clock, async active-high reset
//            bar_valid/bar_wid/bar_id/bar_size_m1/bar_is_noop
//                                barrier request from warp control
//            release_valid       registered pulse, release_wmask valid
//            release_wmask       warps to unstall this cycle
//            stalled_wmask       OR of all pending barrier masks
//            err_dup             registered pulse, duplicate arrival
//            perf_bar_stalls     (VX_BAR_PERF_EN) stalled warp-cycles
//            perf_bar_releases   (VX_BAR_PERF_EN) release count
// Options  : define VX_BAR_PERF_EN to add the performance counters.
// Notes    : bar_req_t / bar_release_t take their widths from the package
//            defaults; instantiate with matching NUM_WARPS / NUM_BARRIERS.
// Revision : 1.0  initial release
// ============================================================================
module vx_barrier_unit
    import vx_barrier_unit_pkg::*;
#(
    parameter int NUM_WARPS    = NUM_WARPS_DEF,
    parameter int NUM_BARRIERS = NUM_BARRIERS_DEF,
    parameter int NW_W         = clog2_min1(NUM_WARPS),
    parameter int NB_W         = clog2_min1(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bar_valid,
    input  logic [NW_W-1:0]      bar_wid,
    input  logic [NB_W-1:0]      bar_id,
    input  logic [NW_W-1:0]      bar_size_m1,
    input  logic                 bar_is_noop,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_wmask,
    output logic [NUM_WARPS-1:0] stalled_wmask,
    output logic                 err_dup
`ifdef VX_BAR_PERF_EN
    ,
    output logic [63:0]          perf_bar_stalls,
    output logic [31:0]          perf_bar_releases
`endif
);

    bar_req_t     w_req;
    bar_release_t w_rel;
    bar_release_t r_rel;
    logic         w_err;
    logic         r_err;

    logic [NUM_BARRIERS-1:0] w_sel;
    logic [NUM_BARRIERS-1:0] w_slot_dup;
    logic [NUM_BARRIERS-1:0] w_slot_last;
    logic [NUM_WARPS-1:0]    w_slot_wmask [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    w_slot_rel   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    w_stalled;
    logic [NUM_WARPS-1:0]    w_onehot;

    assign w_req = '{valid:   bar_valid,
                     wid:     bar_wid,
                     id:      bar_id,
                     size_m1: bar_size_m1,
                     is_noop: bar_is_noop};

    assign w_onehot = NUM_WARPS'(1) << w_req.wid;

    generate
        for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
            // Noop barriers never touch slot state.
            assign w_sel[b] = w_req.valid && !w_req.is_noop && (w_req.id == NB_W'(b));

            vx_barrier_slot #(
                .NUM_WARPS (NUM_WARPS),
                .NW_W      (NW_W)
            ) u_slot (
                .clk         (clk),
                .reset       (reset),
                .req_en      (w_sel[b]),
                .req_wid     (w_req.wid),
                .req_size_m1 (w_req.size_m1),
                .wmask       (w_slot_wmask[b]),
                .is_dup      (w_slot_dup[b]),
                .is_last     (w_slot_last[b]),
                .rel_mask    (w_slot_rel[b])
            );
        end
    endgenerate

    // Decision for the addressed slot, in priority order noop > dup > last.
    always_comb begin
        w_rel = '0;
        w_err = 1'b0;
        if (w_req.valid) begin
            if (w_req.is_noop) begin
                w_rel.valid = 1'b1;
                w_rel.wmask = w_onehot;
            end else if (w_slot_dup[w_req.id]) begin
                w_err = 1'b1;
            end else if (w_slot_last[w_req.id]) begin
                w_rel.valid = 1'b1;
                w_rel.wmask = w_slot_rel[w_req.id];
            end
        end
    end

    // Slot masks are registers, so this view changes on the same edge as the
    // arrival state it summarises.
    always_comb begin
        w_stalled = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_stalled = w_stalled | w_slot_wmask[b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rel <= '0;
            r_err <= 1'b0;
        end else begin
            r_rel <= w_rel;
            r_err <= w_err;
        end
    end

    assign release_valid = r_rel.valid;
    assign release_wmask = r_rel.wmask;
    assign stalled_wmask = w_stalled;
    assign err_dup       = r_err;

`ifdef VX_BAR_PERF_EN
    logic [63:0] r_perf_stalls;
    logic [31:0] r_perf_releases;
    logic [63:0] w_stall_pop;

    always_comb begin
        w_stall_pop = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_stall_pop = w_stall_pop + 64'(w_stalled[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stalls   <= '0;
            r_perf_releases <= '0;
        end else begin
            r_perf_stalls <= r_perf_stalls + w_stall_pop;
            if (r_rel.valid) begin
                r_perf_releases <= r_perf_releases + 32'd1;
            end
        end
    end

    assign perf_bar_stalls   = r_perf_stalls;
    assign perf_bar_releases = r_perf_releases;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_barrier_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_barrier_unit
// Purpose  : Self-checking bench for vx_barrier_unit: directed scenarios
//            followed by randomized requests against a behavioural model
//            (per-barrier arrived-warp sets and agreed sizes).
// Revision : 1.0  initial release
// ============================================================================
module tb_vx_barrier_unit;

    logic       clk;
    logic       reset;
    logic       bar_valid;
    logic [1:0] bar_wid;
    logic [1:0] bar_id;
    logic [1:0] bar_size_m1;
    logic       bar_is_noop;
    logic       release_valid;
    logic [3:0] release_wmask;
    logic [3:0] stalled_wmask;
    logic       err_dup;

    int n_checks;
    int n_pass;

    // Model: set of warps waiting at each barrier, and its agreed size.
    logic [3:0] m_mask [4];
    int         m_size [4];

    vx_barrier_unit u_dut (
        .clk           (clk),
        .reset         (reset),
        .bar_valid     (bar_valid),
        .bar_wid       (bar_wid),
        .bar_id        (bar_id),
        .bar_size_m1   (bar_size_m1),
        .bar_is_noop   (bar_is_noop),
        .release_valid (release_valid),
        .release_wmask (release_wmask),
        .stalled_wmask (stalled_wmask),
        .err_dup       (err_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_stalled();
        logic [3:0] s;
        s = '0;
        for (int b = 0; b < 4; b++) s = s | m_mask[b];
        return s;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 4; b++) begin
            m_mask[b] = '0;
            m_size[b] = 0;
        end
    endtask

    // One request cycle: drive, predict from the model, check after the edge.
    task automatic step(input logic v, input int wid, input int id, input int sz,
                        input logic noop, input string tag);
        logic       exp_rv;
        logic [3:0] exp_rm;
        logic       exp_err;
        logic [3:0] oh;
        @(negedge clk);
        bar_valid   = v;
        bar_wid     = 2'(wid);
        bar_id      = 2'(id);
        bar_size_m1 = 2'(sz);
        bar_is_noop = noop;

        exp_rv  = 1'b0;
        exp_rm  = '0;
        exp_err = 1'b0;
        oh      = 4'b0001 << wid;
        if (v) begin
            if (noop) begin
                exp_rv = 1'b1;
                exp_rm = oh;
            end else if ((m_mask[id] & oh) != 0) begin
                exp_err = 1'b1;
            end else if ($countones(m_mask[id]) == sz) begin
                exp_rv     = 1'b1;
                exp_rm     = m_mask[id] | oh;
                m_mask[id] = '0;
            end else begin
                m_mask[id] = m_mask[id] | oh;
            end
        end

        @(posedge clk);
        #1;
        check({tag, ":release_valid"}, 64'(release_valid), 64'(exp_rv));
        check({tag, ":release_wmask"}, 64'(release_wmask), 64'(exp_rm));
        check({tag, ":err_dup"},       64'(err_dup),       64'(exp_err));
        check({tag, ":stalled_wmask"}, 64'(stalled_wmask), 64'(model_stalled()));
        bar_valid = 1'b0;
    endtask

    task automatic idle(input string tag);
        step(1'b0, 0, 0, 0, 1'b0, tag);
    endtask

    initial begin
        int v, id, wid, sz, noop;
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        bar_valid   = 1'b0;
        bar_wid     = '0;
        bar_id      = '0;
        bar_size_m1 = '0;
        bar_is_noop = 1'b0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check("reset:release_valid", 64'(release_valid), 64'd0);
        check("reset:release_wmask", 64'(release_wmask), 64'd0);
        check("reset:stalled_wmask", 64'(stalled_wmask), 64'd0);
        check("reset:err_dup",       64'(err_dup),       64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Noop barrier releases its own warp at once.
        step(1'b1, 2, 0, 0, 1'b1, "noop");
        idle("noop_after");

        // Four-warp barrier on id 1.
        step(1'b1, 0, 1, 3, 1'b0, "b4_w0");
        step(1'b1, 1, 1, 3, 1'b0, "b4_w1");
        step(1'b1, 2, 1, 3, 1'b0, "b4_w2");
        step(1'b1, 3, 1, 3, 1'b0, "b4_w3");
        idle("b4_after");

        // Two barriers interleaved.
        step(1'b1, 0, 0, 1, 1'b0, "il_0w0");
        step(1'b1, 1, 3, 1, 1'b0, "il_3w1");
        step(1'b1, 2, 0, 1, 1'b0, "il_0w2");
        step(1'b1, 3, 3, 1, 1'b0, "il_3w3");
        idle("il_after");

        // Duplicate arrival leaves the count at one.
        step(1'b1, 1, 0, 2, 1'b0, "dup_w1");
        step(1'b1, 1, 0, 2, 1'b0, "dup_w1_again");
        step(1'b1, 0, 0, 2, 1'b0, "dup_w0");
        step(1'b1, 2, 0, 2, 1'b0, "dup_w2");

        // Size of one without noop releases on first arrival.
        step(1'b1, 3, 2, 0, 1'b0, "size1");

        // Back-to-back reuse of id 2.
        step(1'b1, 0, 2, 1, 1'b0, "reuse_w0");
        step(1'b1, 1, 2, 1, 1'b0, "reuse_w1");
        step(1'b1, 0, 2, 1, 1'b0, "reuse_w0_again");
        idle("reuse_idle");
        step(1'b1, 1, 2, 1, 1'b0, "reuse_close");

        // Asynchronous reset with warps pending.
        step(1'b1, 0, 0, 3, 1'b0, "rst_w0");
        step(1'b1, 1, 0, 3, 1'b0, "rst_w1");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check("async_rst:stalled_wmask", 64'(stalled_wmask), 64'd0);
        check("async_rst:release_valid", 64'(release_valid), 64'd0);
        check("async_rst:release_wmask", 64'(release_wmask), 64'd0);
        check("async_rst:err_dup",       64'(err_dup),       64'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 0, 1, 1, 1'b0, "post_rst");
        step(1'b1, 2, 1, 1, 1'b0, "post_rst_close");

        // Randomized traffic with sizes kept consistent per barrier episode.
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            id   = $urandom_range(0, 3);
            wid  = $urandom_range(0, 3);
            noop = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (m_mask[id] == 0) begin
                sz         = $urandom_range(0, 3);
                m_size[id] = sz;
            end else begin
                sz = m_size[id];
            end
            step(v[0], wid, id, sz, noop[0], "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_barrier_unit.md
Name: vx_barrier_unit

Overview:
- Per-core local barrier manager, directly downstream of the warp-control execute stage.
- Consumes barrier requests carried on the warp-control interface: wid, barrier id, size_m1 and is_noop.
- Tracks arrivals per barrier id and, once the last warp arrives, emits a registered release mask to the warp scheduler.
- The scheduler stalls a warp when it issues a BAR instruction; this block alone decides when that stall lifts.

Parameters:
- NUM_WARPS, 4, warps per core; NW_W = max(1, clog2(NUM_WARPS)).
- NUM_BARRIERS, 4, local barrier ids; NB_W = max(1, clog2(NUM_BARRIERS)).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- bar_valid  in  1  one-cycle barrier request from the warp-control stage (at most one per cycle).
- bar_wid  in  NW_W  arriving warp.
- bar_id  in  NB_W  barrier id.
- bar_size_m1  in  NW_W  number of participating warps minus 1.
- bar_is_noop  in  1  barrier of size 1; release immediately.
- release_valid  out  1  registered pulse: release_wmask is valid.
- release_wmask  out  NUM_WARPS  warps to unstall this cycle.
- stalled_wmask  out  NUM_WARPS  OR of all pending barrier masks (scheduler/debug view).
- err_dup  out  1  registered pulse: duplicate arrival detected.

Behaviour:
- Single clock domain. Reset is asynchronous, active-high, and clears every register. After reset:
  - all counts = 0 and all masks = 0;
  - release_valid = 0, release_wmask = 0, stalled_wmask = 0, err_dup = 0.
- State per barrier b: cnt[b] (NW_W bits) and wmask[b] (NUM_WARPS bits). A barrier is idle when wmask[b] == 0.
- Latency: a request in cycle T produces its release in cycle T+1 (registered outputs). There is no backpressure; the scheduler always accepts a release.
- Per request, evaluated in priority order:
  1. bar_is_noop = 1 → release_wmask = onehot(bar_wid); barrier state untouched.
  2. Else if wmask[bar_id][bar_wid] = 1 (duplicate) → err_dup pulses; state unchanged; no release.
  3. Else if cnt[bar_id] == bar_size_m1 (last arrival) → release_wmask = wmask[bar_id] | onehot(bar_wid); cnt and wmask for that id clear to 0.
  4. Else → cnt[bar_id] += 1; wmask[bar_id] |= onehot(bar_wid); no release.
- release_valid = 1 in cycle T+1 exactly when case 1 or case 3 occurred in cycle T.
- When no release is pending, release_wmask is 0.
- Width rule: the count compare is NW_W-bit unsigned. bar_size_m1 == 0 without is_noop takes case 3 on the first arrival and releases only that warp.
- The first arrival's size_m1 is authoritative. A later arrival with a different size_m1 still compares against the incoming value (the software contract requires consistency); a simulation-only assertion flags a mismatch.
- Because only one request arrives per cycle, a release and a new arrival to the same id cannot collide. The cleared barrier accepts a new first arrival in cycle T+1.
- stalled_wmask is updated in the same edge as cnt/wmask, so it reflects state after the cycle-T request.
- Reset mid-operation clears all pending masks. Warp-stall state in the scheduler is reset by the same signal, so no release is emitted for them.

Optional Feature:
- Macro: VX_BAR_PERF_EN.
- With the macro defined, two extra outputs are added:
  - perf_bar_stalls (64-bit): increments every cycle by popcount(stalled_wmask).
  - perf_bar_releases (32-bit): increments on each release_valid.
  - Both reset to 0 and wrap on overflow.
- Without the macro, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package:
  - bar_req_t struct {valid, wid, id, size_m1, is_noop}, the same layout as the warp-control barrier fields;
  - NB_WIDTH and NW_WIDTH constants;
  - a bar_release_t struct {valid, wmask}.
- One natural sub-module, vx_barrier_slot: holds cnt/wmask for one id and outputs the last/dup/release-mask decision. It is instantiated NUM_BARRIERS times, with bar_id decode in the top level.

Test Plan:
- Noop: bar_valid, wid=2, is_noop=1 → next cycle release_valid=1, release_wmask=4'b0100; stalled_wmask=0.
- 4-warp barrier id 1, size_m1=3: arrivals from w0, w1, w2 on separate cycles → stalled_wmask=4'b0111 and no release. Then w3 arrives → next cycle release_wmask=4'b1111, stalled_wmask=0.
- Two barriers interleaved: id0 size_m1=1 (w0, w2) and id3 size_m1=1 (w1, w3), arriving alternately → two releases, 4'b0101 and 4'b1010, each one cycle after its last arrival.
- Duplicate: id0 size_m1=2, w1 arrives twice → err_dup pulses on the second; cnt stays 1. Then w0 and w2 arrive → release_wmask=4'b0111.
- Back-to-back reuse: id2 size_m1=1 completes (w0, w1). In the following cycle w0 re-arrives at id2 → cnt=1 and no spurious release.
- Reset asserted asynchronously mid-clock with pending 4'b0011 → all outputs 0 immediately. After deassertion, a single arrival of size_m1=1 does not release.
